// File: rtl/icache_refill_ctrl_pkg.sv
// Shared IFU frontend constants and the encoding of the icache refill FSM.
// Imported by the refill controller and its helpers.
package icache_refill_ctrl_pkg;

    localparam int ADDR_WIDTH             = 32;
    localparam int ICACHE_DATA_BLOCK_SIZE = 64;
    localparam int NUM_OFFSET_BITS        = 3;
    localparam int MISS_CNT_WIDTH         = 16;

    // DRAIN waits out a response whose miss was abandoned by a redirect
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] FILL  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones, with a synchronous active-low clear
// that takes priority over the increment enable.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_aL,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Fetch-side icache miss sequencer: one outstanding DRAM block read per miss,
// PC stall and FIFO enqueue gating, and absorption of mid-miss redirects.
module icache_refill_ctrl #(
    parameter int ADDR_WIDTH      = icache_refill_ctrl_pkg::ADDR_WIDTH,
    parameter int BLOCK_SIZE      = icache_refill_ctrl_pkg::ICACHE_DATA_BLOCK_SIZE,
    parameter int NUM_OFFSET_BITS = icache_refill_ctrl_pkg::NUM_OFFSET_BITS,
    parameter int MISS_CNT_WIDTH  = icache_refill_ctrl_pkg::MISS_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_aL,
    input  logic [ADDR_WIDTH-1:0]     pc,
    input  logic                      pc_valid,
    input  logic                      icache_hit,
    input  logic                      recovery_PC_valid,
    input  logic                      ififo_ready_enq,
    output logic                      fifo_enq_valid,
    output logic                      pc_stall,
    output logic                      dram_req_valid,
    output logic [ADDR_WIDTH-1:0]     dram_req_addr,
    input  logic                      dram_req_ready,
    input  logic [BLOCK_SIZE-1:0]     dram_response,
    input  logic                      dram_response_valid,
    output logic                      icache_we,
    output logic [ADDR_WIDTH-1:0]     icache_waddr,
    output logic [BLOCK_SIZE-1:0]     icache_wdata,
    output logic                      miss_busy,
    output logic [MISS_CNT_WIDTH-1:0] miss_count
);

    import icache_refill_ctrl_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << NUM_OFFSET_BITS) - 1);

    logic [2:0]                state;
    logic [ADDR_WIDTH-1:0]     miss_addr;
    logic [BLOCK_SIZE-1:0]     fill_data;
    logic [ADDR_WIDTH-1:0]     pc_aligned;
    logic                      in_idle;
    logic                      start_miss;
    logic [MISS_CNT_WIDTH-1:0] miss_cnt_raw;

    assign pc_aligned = pc & ~OFFSET_MASK;
    assign in_idle    = (state == IDLE);
    assign start_miss = in_idle & pc_valid & ~icache_hit & ~recovery_PC_valid;

    // A response is only consumed in WAIT or DRAIN; stray pulses elsewhere fall through
    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            state     <= IDLE;
            miss_addr <= '0;
            fill_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_miss) begin
                        miss_addr <= pc_aligned;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (recovery_PC_valid) begin
                        state <= IDLE;
                    end else if (dram_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (dram_response_valid) begin
                        fill_data <= dram_response;
                        state     <= FILL;
                    end else if (recovery_PC_valid) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (dram_response_valid) begin
                        state <= IDLE;
                    end
                end
                FILL:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    sat_counter #(
        .WIDTH (MISS_CNT_WIDTH)
    ) u_miss_cnt (
        .clk    (clk),
        .rst_aL (rst_aL),
        .inc    (start_miss),
        .count  (miss_cnt_raw)
    );

    // Every output is forced low while reset is asserted, not just after the edge
    assign fifo_enq_valid = rst_aL & in_idle & pc_valid & icache_hit & ififo_ready_enq
                            & ~recovery_PC_valid;
    assign pc_stall       = rst_aL & ~recovery_PC_valid
                            & (~in_idle | (pc_valid & ~icache_hit)
                               | (pc_valid & icache_hit & ~ififo_ready_enq));
    assign dram_req_valid = rst_aL & (state == REQ);
    assign dram_req_addr  = dram_req_valid ? miss_addr : '0;
    assign icache_we      = rst_aL & (state == FILL);
    assign icache_waddr   = icache_we ? miss_addr : '0;
    assign icache_wdata   = icache_we ? fill_data : '0;
    assign miss_busy      = rst_aL & ~in_idle;
    assign miss_count     = rst_aL ? miss_cnt_raw : '0;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: a transaction-level miss model is
// compared against the DUT every cycle, plus hand-computed spot checks.
module tb_icache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst_aL = 1'b0;
    logic [31:0] pc = '0;
    logic        pc_valid = 1'b0;
    logic        icache_hit = 1'b0;
    logic        recovery_PC_valid = 1'b0;
    logic        ififo_ready_enq = 1'b0;
    logic        dram_req_ready = 1'b0;
    logic [63:0] dram_response = '0;
    logic        dram_response_valid = 1'b0;

    logic        fifo_enq_valid, pc_stall, dram_req_valid, icache_we, miss_busy;
    logic [31:0] dram_req_addr, icache_waddr;
    logic [63:0] icache_wdata;
    logic [15:0] miss_count;

    logic        s_fifo_enq_valid, s_pc_stall, s_dram_req_valid, s_icache_we, s_miss_busy;
    logic [31:0] s_dram_req_addr, s_icache_waddr;
    logic [63:0] s_icache_wdata;
    logic [3:0]  s_miss_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    icache_refill_ctrl dut (
        .clk(clk), .rst_aL(rst_aL), .pc(pc), .pc_valid(pc_valid), .icache_hit(icache_hit),
        .recovery_PC_valid(recovery_PC_valid), .ififo_ready_enq(ififo_ready_enq),
        .fifo_enq_valid(fifo_enq_valid), .pc_stall(pc_stall),
        .dram_req_valid(dram_req_valid), .dram_req_addr(dram_req_addr),
        .dram_req_ready(dram_req_ready), .dram_response(dram_response),
        .dram_response_valid(dram_response_valid), .icache_we(icache_we),
        .icache_waddr(icache_waddr), .icache_wdata(icache_wdata),
        .miss_busy(miss_busy), .miss_count(miss_count)
    );

    // Narrow-counter copy so saturation is reachable in a short run
    icache_refill_ctrl #(.MISS_CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst_aL(rst_aL), .pc(pc), .pc_valid(pc_valid), .icache_hit(icache_hit),
        .recovery_PC_valid(recovery_PC_valid), .ififo_ready_enq(ififo_ready_enq),
        .fifo_enq_valid(s_fifo_enq_valid), .pc_stall(s_pc_stall),
        .dram_req_valid(s_dram_req_valid), .dram_req_addr(s_dram_req_addr),
        .dram_req_ready(dram_req_ready), .dram_response(dram_response),
        .dram_response_valid(dram_response_valid), .icache_we(s_icache_we),
        .icache_waddr(s_icache_waddr), .icache_wdata(s_icache_wdata),
        .miss_busy(s_miss_busy), .miss_count(s_miss_count)
    );

    // Model: a miss is "busy" until filled or dropped; "issued" once DRAM took
    // the request; "abandoned" once a redirect arrived while waiting.
    bit          m_busy = 0, m_issued = 0, m_abandoned = 0, m_write = 0;
    logic [31:0] m_addr = '0;
    logic [63:0] m_data = '0;
    int          m_count = 0;

    always @(posedge clk) begin
        if (!rst_aL) begin
            m_busy = 0; m_issued = 0; m_abandoned = 0; m_write = 0;
            m_addr = '0; m_data = '0; m_count = 0;
        end else if (m_write) begin
            m_write = 0;
        end else if (!m_busy) begin
            if (pc_valid && !icache_hit && !recovery_PC_valid) begin
                m_busy = 1; m_issued = 0; m_abandoned = 0;
                m_addr = pc - (pc % 32'd8);
                m_count++;
            end
        end else if (!m_issued) begin
            if (recovery_PC_valid) m_busy = 0;
            else if (dram_req_ready) m_issued = 1;
        end else if (!m_abandoned) begin
            if (dram_response_valid) begin
                m_data = dram_response; m_write = 1; m_busy = 0;
            end else if (recovery_PC_valid) begin
                m_abandoned = 1;
            end
        end else if (dram_response_valid) begin
            m_busy = 0;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        bit          idle, e_req, e_we;
        logic [63:0] e_cnt, e_cnt_sat;
        idle      = !m_busy && !m_write;
        e_req     = rst_aL && m_busy && !m_issued;
        e_we      = rst_aL && m_write;
        e_cnt     = !rst_aL ? 64'd0 : (m_count > 65535 ? 64'd65535 : 64'(m_count));
        e_cnt_sat = !rst_aL ? 64'd0 : (m_count > 15 ? 64'd15 : 64'(m_count));
        checkOutput("fifo_enq_valid", 64'(fifo_enq_valid),
                    64'(rst_aL && idle && pc_valid && icache_hit && ififo_ready_enq
                        && !recovery_PC_valid));
        checkOutput("pc_stall", 64'(pc_stall),
                    64'(rst_aL && !recovery_PC_valid && (!idle || (pc_valid && !icache_hit)
                        || (pc_valid && icache_hit && !ififo_ready_enq))));
        checkOutput("dram_req_valid", 64'(dram_req_valid), 64'(e_req));
        checkOutput("dram_req_addr", 64'(dram_req_addr), e_req ? 64'(m_addr) : 64'd0);
        checkOutput("icache_we", 64'(icache_we), 64'(e_we));
        checkOutput("icache_waddr", 64'(icache_waddr), e_we ? 64'(m_addr) : 64'd0);
        checkOutput("icache_wdata", icache_wdata, e_we ? m_data : 64'd0);
        checkOutput("miss_busy", 64'(miss_busy), 64'(rst_aL && !idle));
        checkOutput("miss_count", 64'(miss_count), e_cnt);
        checkOutput("miss_count_sat4", 64'(s_miss_count), e_cnt_sat);
    end

    task automatic applyStimulus(input logic rst, input logic pv, input logic [31:0] p,
                                 input logic hit, input logic rec, input logic frdy,
                                 input logic drdy, input logic rvld, input logic [63:0] resp);
        @(posedge clk);
        #1;
        rst_aL = rst; pc_valid = pv; pc = p; icache_hit = hit; recovery_PC_valid = rec;
        ififo_ready_enq = frdy; dram_req_ready = drdy; dram_response_valid = rvld;
        dram_response = resp;
        #1;
    endtask

    initial begin
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_busy", 64'(miss_busy), 64'd0);
        checkOutput("reset_count", 64'(miss_count), 64'd0);

        applyStimulus(1, 1, 32'h100, 1, 0, 1, 0, 0, 0);
        checkOutput("hit_enq", 64'(fifo_enq_valid), 64'd1);
        checkOutput("hit_stall", 64'(pc_stall), 64'd0);
        checkOutput("hit_no_req", 64'(dram_req_valid), 64'd0);

        applyStimulus(1, 1, 32'h10C, 0, 0, 1, 0, 0, 0);
        checkOutput("miss_stall", 64'(pc_stall), 64'd1);
        applyStimulus(1, 1, 32'h10C, 0, 0, 1, 0, 1, 64'h55);
        checkOutput("miss_req", 64'(dram_req_valid), 64'd1);
        checkOutput("miss_req_addr", 64'(dram_req_addr), 64'h108);
        checkOutput("miss_count1", 64'(miss_count), 64'd1);
        applyStimulus(1, 1, 32'h10C, 0, 0, 1, 1, 0, 0);
        applyStimulus(1, 1, 32'h10C, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 1, 32'h10C, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 1, 32'h10C, 0, 0, 1, 0, 1, 64'hDEADBEEF_00000013);
        applyStimulus(1, 1, 32'h10C, 1, 0, 1, 0, 0, 0);
        checkOutput("fill_we", 64'(icache_we), 64'd1);
        checkOutput("fill_waddr", 64'(icache_waddr), 64'h108);
        checkOutput("fill_wdata", icache_wdata, 64'hDEADBEEF_00000013);
        applyStimulus(1, 1, 32'h10C, 1, 0, 1, 0, 0, 0);
        checkOutput("refetch_we", 64'(icache_we), 64'd0);
        checkOutput("refetch_enq", 64'(fifo_enq_valid), 64'd1);

        applyStimulus(1, 1, 32'h200, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 1, 32'h200, 0, 0, 1, 1, 0, 0);
        applyStimulus(1, 1, 32'h200, 0, 1, 1, 0, 0, 0);
        checkOutput("wait_redirect_stall", 64'(pc_stall), 64'd0);
        applyStimulus(1, 1, 32'h200, 0, 1, 1, 0, 0, 0);
        checkOutput("drain_busy", 64'(miss_busy), 64'd1);
        applyStimulus(1, 1, 32'h200, 0, 0, 1, 0, 0, 0);
        checkOutput("drain_stall", 64'(pc_stall), 64'd1);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 1, 64'hBAD);
        checkOutput("drain_no_we", 64'(icache_we), 64'd0);
        applyStimulus(1, 1, 32'h304, 0, 0, 1, 0, 0, 0);
        checkOutput("post_drain_idle", 64'(miss_busy), 64'd0);
        applyStimulus(1, 1, 32'h304, 0, 1, 1, 1, 0, 0);
        checkOutput("req_redirect_addr", 64'(dram_req_addr), 64'h300);
        checkOutput("req_redirect_stall", 64'(pc_stall), 64'd0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("req_redirect_idle", 64'(miss_busy), 64'd0);

        applyStimulus(1, 1, 32'h40C, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 1, 32'h40C, 0, 0, 1, 1, 0, 0);
        applyStimulus(1, 1, 32'h40C, 0, 1, 1, 0, 1, 64'h12345678_9ABCDEF0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("race_we", 64'(icache_we), 64'd1);
        checkOutput("race_waddr", 64'(icache_waddr), 64'h408);
        checkOutput("race_wdata", icache_wdata, 64'h12345678_9ABCDEF0);
        checkOutput("race_count", 64'(miss_count), 64'd4);

        applyStimulus(1, 1, 32'h500, 1, 0, 0, 0, 0, 0);
        checkOutput("full_enq", 64'(fifo_enq_valid), 64'd0);
        checkOutput("full_stall", 64'(pc_stall), 64'd1);
        applyStimulus(1, 1, 32'h500, 1, 0, 1, 0, 0, 0);
        checkOutput("ready_enq", 64'(fifo_enq_valid), 64'd1);

        applyStimulus(1, 0, 0, 0, 0, 1, 0, 1, 64'hFFFF);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("stray_idle_we", 64'(icache_we), 64'd0);

        applyStimulus(1, 1, 32'h600, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 1, 32'h600, 0, 0, 1, 1, 0, 0);
        applyStimulus(0, 1, 32'h600, 0, 0, 1, 0, 0, 0);
        checkOutput("rst_busy", 64'(miss_busy), 64'd0);
        checkOutput("rst_stall", 64'(pc_stall), 64'd0);
        checkOutput("rst_count", 64'(miss_count), 64'd0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 1, 64'hABCD);
        checkOutput("post_rst_count", 64'(miss_count), 64'd0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("post_rst_no_we", 64'(icache_we), 64'd0);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 1, 32'h700, 0, 0, 1, 0, 0, 0);
            applyStimulus(1, 1, 32'h700, 0, 1, 1, 1, 0, 0);
        end
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("count20", 64'(miss_count), 64'd20);
        checkOutput("sat4_holds", 64'(s_miss_count), 64'hF);

        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
Fetch-side controller that sequences the instruction cache on a miss.
- Detects a miss on the current fetch PC, issues one block request to DRAM, and writes the returned block into the icache.
- Holds the PC register and gates instruction-FIFO enqueue while busy.
- Absorbs recovery redirects that arrive mid-miss.
- Sits between the PC register, icache, instruction FIFO and the DRAM port inside the IFU.

Parameters:
ADDR_WIDTH, 32, fetch address width
BLOCK_SIZE, 64, icache block width in bits (two 32-bit instructions)
NUM_OFFSET_BITS, 3, byte-offset bits within a block
MISS_CNT_WIDTH, 16, width of saturating miss counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst_aL  in  1  synchronous active-low reset
pc  in  ADDR_WIDTH  current fetch PC
pc_valid  in  1  pc holds a fetch to perform this cycle
icache_hit  in  1  icache lookup result for pc (combinational, same cycle)
recovery_PC_valid  in  1  backend redirect this cycle; PC reloads next edge
ififo_ready_enq  in  1  instruction FIFO can accept
fifo_enq_valid  out  1  enqueue selected instruction this cycle
pc_stall  out  1  hold PC register (do not advance)
dram_req_valid  out  1  block read request
dram_req_addr  out  ADDR_WIDTH  block-aligned request address
dram_req_ready  in  1  DRAM accepts request
dram_response  in  BLOCK_SIZE  returned block
dram_response_valid  in  1  block valid, single-cycle pulse
icache_we  out  1  icache write enable
icache_waddr  out  ADDR_WIDTH  block-aligned write address
icache_wdata  out  BLOCK_SIZE  block to write
miss_busy  out  1  state != IDLE
miss_count  out  MISS_CNT_WIDTH  saturating count of misses started

Behaviour:
Reset:
- On rst_aL=0 at an edge: state=IDLE and miss_addr=0, fill_data=0, miss_count=0.
- All outputs read 0 during and after reset.
- Reset mid-miss abandons the miss with no icache write; any later dram_response_valid seen in IDLE is ignored.

FSM states: IDLE, REQ, WAIT, FILL, DRAIN.
- IDLE:
  - pc_valid & !icache_hit & !recovery_PC_valid: latch miss_addr = pc with low NUM_OFFSET_BITS zeroed; miss_count+1 (saturating at all-ones); go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - dram_req_valid=1, dram_req_addr=miss_addr.
  - recovery_PC_valid: go to IDLE. Recovery has priority over dram_req_ready; the request counts as not issued.
  - Else if dram_req_ready: go to WAIT.
- WAIT:
  - dram_response_valid: latch fill_data and go to FILL. This applies even if recovery_PC_valid is high in the same cycle, because the block is correct for miss_addr.
  - Else if recovery_PC_valid: go to DRAIN.
- DRAIN:
  - dram_response_valid: go to IDLE with no icache write.
  - Further recovery pulses have no effect.
- FILL:
  - icache_we=1 for exactly one cycle, icache_waddr=miss_addr, icache_wdata=fill_data.
  - Always go to IDLE; recovery in FILL does not suppress the write.

Response pulses:
- dram_response_valid in IDLE or REQ is a protocol error and is dropped.
- Only one request is outstanding at a time.

Combinational outputs:
- fifo_enq_valid = (state==IDLE) & pc_valid & icache_hit & ififo_ready_enq & !recovery_PC_valid.
- pc_stall = !recovery_PC_valid & ((state!=IDLE) | (pc_valid & !icache_hit) | (pc_valid & icache_hit & !ififo_ready_enq)).
- Recovery never stalls the PC.

Latency:
- Best case from miss detected in IDLE to refetch: detect→REQ (1), REQ→WAIT (accept), response→FILL, FILL→IDLE.
- The re-lookup hits at earliest 2 cycles after the response pulse.

Decomposition:
- Shared frontend package holds: ADDR_WIDTH, ICACHE_DATA_BLOCK_SIZE, NUM_OFFSET_BITS, and the refill FSM state encoding (3-bit localparam enum IDLE=0, REQ=1, WAIT=2, FILL=3, DRAIN=4).
- One sub-module: sat_counter (parameterised width, synchronous active-low clear, increment enable), used for miss_count.
- Block alignment and output decode stay in the top module.

Test Plan:
- Hit path: pc=0x100, pc_valid=1, icache_hit=1, ififo_ready_enq=1 → fifo_enq_valid=1, pc_stall=0, state stays IDLE, no dram_req_valid.
- Miss/refill: pc=0x10C, hit=0; DRAM ready immediately, response 3 cycles later with data 0xDEADBEEF_00000013 → dram_req_addr=0x108, pc_stall=1 throughout, icache_we=1 for one cycle with waddr=0x108 and that data, then IDLE, miss_count=1.
- Redirect in WAIT, no response yet: recovery_PC_valid pulse → state DRAIN, pc_stall=0 that cycle; later response → no icache_we, return to IDLE; a new miss can then start.
- Redirect and response in the same WAIT cycle → FILL and icache_we=1 (block written); redirect in REQ with dram_req_ready=1 → IDLE, no WAIT.
- FIFO full: hit=1, ififo_ready_enq=0 → fifo_enq_valid=0, pc_stall=1; ready returns → enqueue once.
- Reset mid-WAIT: rst_aL=0 for 1 cycle → all outputs 0, miss_count=0; a following stray response → ignored, no write. Saturation: force 65536 misses → miss_count holds 0xFFFF.
